chip_fmc_dma: RTL
=================

// Module: chip_fmc_dma
// PURPOSE
// - Chip-side initiator for the FMC port: turns one command (dir, base addr, beat count) into a burst on CHIPFMC_*/FMCCHIP_*.
// - Read: pulls FMCCHIP_RdDat beats, hands them to on-chip consumer. Write: takes on-chip producer beats, drives CHIPFMC_WrDat.
// - Sits between chip buffers (GLB) and the FMC pins; a single shared address bus serves both directions.
// PARAMETERS
// - ADDR_WIDTH  32   FMC address width (beat/word address)
// - DATA_WIDTH  128  beat width
// - LEN_WIDTH   16   burst length field; cmd_len = beats-1
// PORTS
// - clk               in   1           single clock
// - rst               in   1           synchronous, active-high reset
// - cmd_vld           in   1           command valid
// - cmd_rdy           out  1           command accepted when vld&rdy
// - cmd_wr            in   1           1=write to DDR, 0=read from DDR
// - cmd_addr          in   ADDR_WIDTH  base word address
// - cmd_len           in   LEN_WIDTH   beats-1
// - rd_dat            out  DATA_WIDTH  read beat to chip consumer
// - rd_dat_vld        out  1           read beat valid
// - rd_dat_rdy        in   1           consumer ready
// - wr_dat            in   DATA_WIDTH  write beat from chip producer
// - wr_dat_vld        in   1           write beat valid
// - wr_dat_rdy        out  1           producer handshake
// - busy              out  1           burst in progress
// - done              out  1           1-cycle pulse, burst complete
// - CHIPFMC_Addr      out  ADDR_WIDTH  current beat address
// - FMCCHIP_RdDat     in   DATA_WIDTH  read data from FMC
// - FMCCHIP_RdDatVld  in   1           read data valid
// - CHIPFMC_RdDatRdy  out  1           chip ready for read beat
// - CHIPFMC_WrDat     out  DATA_WIDTH  write data to FMC
// - CHIPFMC_WrDatVld  out  1           write data valid
// - FMCCHIP_WrDatRdy  in   1           FMC ready for write beat
// BEHAVIOUR
// - Reset: state IDLE; cmd_rdy=1 after reset deasserts; all vld/rdy/busy/done=0; CHIPFMC_Addr=0; data regs=0; beat counter=0.
// - FSM IDLE -> RD|WR on cmd_vld&cmd_rdy (latch addr, len, dir); RD|WR -> DONE when last beat handshakes on FMC side
//   (RD: additionally when read skid is empty); DONE -> IDLE next cycle, done=1 exactly in DONE. cmd_rdy=1 only in IDLE.
// - Address: CHIPFMC_Addr=base while active; +1 (mod 2^ADDR_WIDTH, wraps silently) on each FMC-side beat handshake.
//   Held stable while a beat is pending; held at last value in IDLE.
// - RD: CHIPFMC_RdDatRdy = skid-not-full & beats remaining; FMC beat accepted on FMCCHIP_RdDatVld&CHIPFMC_RdDatRdy.
//   Beats beyond cmd_len+1 are never accepted (rdy=0). rd_dat_* driven from skid; order preserved.
// - WR: wr_dat_rdy = skid-not-full & beats remaining; CHIPFMC_WrDatVld from skid, stays high with stable data until FMCCHIP_WrDatRdy.
// - Skids: 2-entry, registered outputs; full-throughput 1 beat/clk when both sides ready; latency input->output = 1 clk.
// - Unused direction: rd_dat_vld=0 in WR, CHIPFMC_WrDatVld=0 / wr_dat_rdy=0 in RD.
// - Beat counter counts FMC-side handshakes 0..cmd_len; cmd_len=0 is a 1-beat burst; max 2^LEN_WIDTH beats.
// - Simultaneous: push and pop of skid in same cycle keeps occupancy; last beat + consumer pop same cycle -> DONE next clk.
// - Reset mid-burst: abort immediately, skids flushed, no done pulse, outputs to reset values next clk.
// STRUCTURE
// - Shared pkg: FSM state encoding (IDLE/RD/WR/DONE), DIR_RD/DIR_WR constants; widths stay module parameters.
// - One sub-module: chip_fmc_skid (2-entry valid/ready buffer, param DATA_WIDTH), instanced once per direction.
// - Top: FSM, beat counter, address register, muxing of handshakes per direction.
// TESTING
// - Read len=3 @0x100, FMC vld every clk, consumer always rdy -> 4 beats D0..D3 in order, Addr 0x100..0x103, done 1 clk after last.
// - Read len=7, rd_dat_rdy low 5 clk mid-burst -> CHIPFMC_RdDatRdy drops within 2 beats, no beat lost/duplicated, 8 beats out.
// - Write len=0 @0xFFFF_FFFF, FMCCHIP_WrDatRdy low 3 clk -> WrDat/WrDatVld stable 3 clk, 1 beat sent, Addr wraps to 0, done.
// - FMC offers 6 read beats for len=3 -> exactly 4 accepted, RdDatRdy=0 after 4th, cmd_rdy=1 two clk later.
// - cmd_vld held during busy -> cmd_rdy=0 until IDLE; back-to-back read then write bursts both complete.
// - rst=1 mid write burst (beat 2 of 8) -> next clk all vld=0, busy=0, no done, cmd_rdy=1 after release.

Source files
------------

// File: rtl/chip_fmc_dma_pkg.sv
// Shared FSM encoding and direction constants for the FMC burst engine.
// No timing of its own; types only.
// No flow control; types only.
package chip_fmc_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/chip_fmc_skid.sv
// 2-entry valid/ready buffer with registered storage, one per burst direction.
// Latency: a beat pushed on one edge is presented on the output the next cycle.
// Backpressure: in_rdy_o drops only when both entries hold data; 1 beat/clk with both sides ready.
module chip_fmc_skid #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic [DATA_WIDTH-1:0] in_dat_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [DATA_WIDTH-1:0] out_dat_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  push;
  logic                  pop;

  assign in_rdy_o  = (cnt_q != 2'd2);
  assign out_vld_o = (cnt_q != 2'd0);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;
  assign push      = in_vld_i & in_rdy_o;
  assign pop       = out_vld_o & out_rdy_i;

  // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/chip_fmc_dma.sv
// Chip-side FMC burst initiator: one command becomes a read or write burst of cmd_len+1 beats.
// Latency: 1 clk through each skid; done pulses the cycle after the last beat leaves the engine.
// Backpressure: each direction stalls through its 2-entry skid; beats beyond the burst are refused.
module chip_fmc_dma
  import chip_fmc_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic                  rd_dat_vld,
  input  logic                  rd_dat_rdy,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  wr_dat_vld,
  output logic                  wr_dat_rdy,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] CHIPFMC_Addr,
  input  logic [DATA_WIDTH-1:0] FMCCHIP_RdDat,
  input  logic                  FMCCHIP_RdDatVld,
  output logic                  CHIPFMC_RdDatRdy,
  output logic [DATA_WIDTH-1:0] CHIPFMC_WrDat,
  output logic                  CHIPFMC_WrDatVld,
  input  logic                  FMCCHIP_WrDatRdy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;   // FMC-side handshakes so far
  logic [LEN_WIDTH:0]    in_cnt_q, in_cnt_d;       // beats taken into the active skid
  logic                  fmc_more_q, fmc_more_d;   // FMC-side beats still owed

  logic st_rd, st_wr;
  logic cmd_hs, in_more, fmc_hs, in_hs, last_hs, rd_drained;

  logic                  rd_in_vld, rd_in_rdy, rd_out_vld, rd_out_rdy;
  logic [DATA_WIDTH-1:0] rd_out_dat;
  logic [1:0]            rd_cnt;
  logic                  wr_in_vld, wr_in_rdy, wr_out_vld, wr_out_rdy;
  logic [DATA_WIDTH-1:0] wr_out_dat;
  logic [1:0]            wr_cnt;

  assign st_rd   = (state_q == ST_RD);
  assign st_wr   = (state_q == ST_WR);
  assign cmd_rdy = (state_q == ST_IDLE) & ~rst;
  assign cmd_hs  = cmd_vld & cmd_rdy;
  // The extra counter bit lets a 2^LEN_WIDTH-beat burst terminate cleanly.
  assign in_more = (in_cnt_q <= {1'b0, len_q});

  // Read path: FMC -> skid -> consumer.
  assign rd_in_vld        = FMCCHIP_RdDatVld & st_rd & in_more;
  assign CHIPFMC_RdDatRdy = st_rd & rd_in_rdy & in_more;
  assign rd_dat_vld       = rd_out_vld & st_rd;
  assign rd_out_rdy       = rd_dat_rdy & st_rd;
  assign rd_dat           = rd_out_dat;

  // Write path: producer -> skid -> FMC.
  assign wr_in_vld        = wr_dat_vld & st_wr & in_more;
  assign wr_dat_rdy       = st_wr & wr_in_rdy & in_more;
  assign CHIPFMC_WrDatVld = wr_out_vld & st_wr;
  assign wr_out_rdy       = FMCCHIP_WrDatRdy & st_wr;
  assign CHIPFMC_WrDat    = wr_out_dat;

  assign fmc_hs  = (st_rd & FMCCHIP_RdDatVld & CHIPFMC_RdDatRdy) |
                   (st_wr & CHIPFMC_WrDatVld & FMCCHIP_WrDatRdy);
  assign in_hs   = (st_rd & FMCCHIP_RdDatVld & CHIPFMC_RdDatRdy) |
                   (st_wr & wr_dat_vld & wr_dat_rdy);
  assign last_hs = fmc_hs & fmc_more_q & (beat_cnt_q == len_q);
  // Read skid empties this cycle (or already is), so the burst can close.
  assign rd_drained = (rd_cnt == 2'd0) | ((rd_cnt == 2'd1) & rd_dat_vld & rd_dat_rdy);

  assign busy         = st_rd | st_wr;
  assign done         = (state_q == ST_DONE);
  assign CHIPFMC_Addr = addr_q;

  chip_fmc_skid #(.DATA_WIDTH(DATA_WIDTH)) u_rd_skid (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (rd_in_vld),
    .in_rdy_o  (rd_in_rdy),
    .in_dat_i  (FMCCHIP_RdDat),
    .out_vld_o (rd_out_vld),
    .out_rdy_i (rd_out_rdy),
    .out_dat_o (rd_out_dat),
    .cnt_o     (rd_cnt)
  );

  chip_fmc_skid #(.DATA_WIDTH(DATA_WIDTH)) u_wr_skid (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (wr_in_vld),
    .in_rdy_o  (wr_in_rdy),
    .in_dat_i  (wr_dat),
    .out_vld_o (wr_out_vld),
    .out_rdy_i (wr_out_rdy),
    .out_dat_o (wr_out_dat),
    .cnt_o     (wr_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a read closes only once its skid has drained to the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_hs) state_d = (cmd_wr == DIR_WR) ? ST_WR : ST_RD;
      ST_RD:   if (!fmc_more_q && rd_drained) state_d = ST_DONE;
      ST_WR:   if (last_hs) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: latch the command, then advance address and counters per beat.
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    in_cnt_d   = in_cnt_q;
    fmc_more_d = fmc_more_q;
    if (cmd_hs) begin
      addr_d     = cmd_addr;
      len_d      = cmd_len;
      beat_cnt_d = '0;
      in_cnt_d   = '0;
      fmc_more_d = 1'b1;
    end else begin
      if (fmc_hs) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (last_hs) fmc_more_d = 1'b0;
        else         beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
      end
      if (in_hs) in_cnt_d = in_cnt_q + (LEN_WIDTH+1)'(1);
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      in_cnt_q   <= '0;
      fmc_more_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      in_cnt_q   <= in_cnt_d;
      fmc_more_q <= fmc_more_d;
    end
  end

  // Write-skid occupancy is not needed to close a write burst.
  logic unused_wr_cnt;
  assign unused_wr_cnt = ^wr_cnt;

endmodule
